iob_vexriscv_bus_arbiter: RTL and testbench

Two-to-one arbiter that lets the VexRiscv wrapper's instruction and data IOb-native buses share a single memory port (internal SRAM or external memory controller). Requests are granted round-robin on conflict, and the grant is locked until the shared port accepts. An in-order tag FIFO routes each read response (`rvalid`) back to the requester that issued it.

---
 rtl/iob_vexriscv_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_iob_vexriscv_bus_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob_vexriscv_bus_arbiter.sv
// Two-to-one IOb-native bus arbiter for the VexRiscv instruction and data buses.
// Round-robin on conflict, grant held until the shared port accepts, and an
// in-order tag FIFO that steers each read response back to its issuer.
module iob_vexriscv_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ibus_valid,
    input  logic [ADDR_W-1:0]              ibus_addr,
    input  logic [DATA_W-1:0]              ibus_wdata,
    input  logic [DATA_W/8-1:0]            ibus_wstrb,
    output logic                           ibus_ready,
    output logic                           ibus_rvalid,
    output logic [DATA_W-1:0]              ibus_rdata,
    input  logic                           dbus_valid,
    input  logic [ADDR_W-1:0]              dbus_addr,
    input  logic [DATA_W-1:0]              dbus_wdata,
    input  logic [DATA_W/8-1:0]            dbus_wstrb,
    output logic                           dbus_ready,
    output logic                           dbus_rvalid,
    output logic [DATA_W-1:0]              dbus_rdata,
    output logic                           m_valid,
    output logic [ADDR_W-1:0]              m_addr,
    output logic [DATA_W-1:0]              m_wdata,
    output logic [DATA_W/8-1:0]            m_wstrb,
    input  logic                           m_ready,
    input  logic                           m_rvalid,
    input  logic [DATA_W-1:0]              m_rdata,
    output logic [$clog2(MAX_PENDING):0]   pending,
    output logic                           err_rvalid
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        REQ_IBUS = 1'b0,
        REQ_DBUS = 1'b1
    } req_e;

    req_e             last_grant_q, last_grant_d;
    logic             lock_q, lock_d;
    req_e             lock_id_q, lock_id_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             err_q, err_d;
    req_e             tag_mem [MAX_PENDING];

    req_e grant;
    logic granted_valid;
    logic full;
    logic empty;
    logic accept;
    logic push;
    logic pop;
    req_e head;

    assign full  = (pending_q == CNT_W'(MAX_PENDING));
    assign empty = (pending_q == '0);
    assign head  = tag_mem[rd_ptr_q];

    // Pick the requester that owns the shared port this cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant = REQ_IBUS;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (ibus_valid && dbus_valid) begin
            grant = (last_grant_q == REQ_IBUS) ? REQ_DBUS : REQ_IBUS;
        end else if (dbus_valid) begin
            grant = REQ_DBUS;
        end
    end

    assign granted_valid = (grant == REQ_DBUS) ? dbus_valid : ibus_valid;
    assign m_valid       = granted_valid & ~full;
    assign m_addr        = (grant == REQ_DBUS) ? dbus_addr  : ibus_addr;
    assign m_wdata       = (grant == REQ_DBUS) ? dbus_wdata : ibus_wdata;
    assign m_wstrb       = (grant == REQ_DBUS) ? dbus_wstrb : ibus_wstrb;

    // Ready is only raised when a real transfer happens, so an idle bus shows no ready.
    assign accept     = m_valid & m_ready;
    assign ibus_ready = accept & (grant == REQ_IBUS);
    assign dbus_ready = accept & (grant == REQ_DBUS);

    assign push = accept & (m_wstrb == '0);
    assign pop  = m_rvalid & ~empty;

    assign ibus_rdata  = m_rdata;
    assign dbus_rdata  = m_rdata;
    assign ibus_rvalid = pop & (head == REQ_IBUS);
    assign dbus_rvalid = pop & (head == REQ_DBUS);

    assign pending    = pending_q;
    assign err_rvalid = err_q;

    // Next-state for arbitration history, lock, FIFO bookkeeping and error flag.
    always_comb begin
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pending_d    = pending_q;
        err_d        = err_q;

        if (accept) begin
            last_grant_d = grant;
            lock_d       = 1'b0;
        end else if (m_valid) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   pending_d = pending_q + CNT_W'(1);
            2'b01:   pending_d = pending_q - CNT_W'(1);
            default: pending_d = pending_q;
        endcase

        if (m_rvalid && empty) err_d = 1'b1;
    end

    // Control registers; reset drops every outstanding tag.
    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= REQ_DBUS;
            lock_q       <= 1'b0;
            lock_id_q    <= REQ_IBUS;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pending_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pending_q    <= pending_d;
            err_q        <= err_d;
        end
    end

    // Tag storage, written with the granted requester on each read accept.
    // NOTE: the tag array is not reset; entries are only read while pending says they are valid.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr_q] <= grant;
    end

endmodule

// File: tb/tb_iob_vexriscv_bus_arbiter.sv
// Self-checking bench for iob_vexriscv_bus_arbiter: directed scenarios plus a
// randomized run, all compared against a queue-based transaction model.
module tb_iob_vexriscv_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAXP   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ibus_valid, dbus_valid;
    logic [ADDR_W-1:0] ibus_addr, dbus_addr;
    logic [DATA_W-1:0] ibus_wdata, dbus_wdata;
    logic [3:0]        ibus_wstrb, dbus_wstrb;
    logic              ibus_ready, ibus_rvalid, dbus_ready, dbus_rvalid;
    logic [DATA_W-1:0] ibus_rdata, dbus_rdata;
    logic              m_valid, m_ready, m_rvalid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    logic [3:0]        m_wstrb;
    logic [2:0]        pending;
    logic              err_rvalid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who won last, lock owner, and the queue of outstanding read issuers.
    bit mdl_last;
    bit mdl_lock;
    bit mdl_lock_id;
    bit mdl_err;
    bit mdl_q[$];

    iob_vexriscv_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .rst(rst),
        .ibus_valid(ibus_valid), .ibus_addr(ibus_addr), .ibus_wdata(ibus_wdata), .ibus_wstrb(ibus_wstrb),
        .ibus_ready(ibus_ready), .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
        .dbus_valid(dbus_valid), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_ready(dbus_ready), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .pending(pending), .err_rvalid(err_rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ibus_valid = 0; dbus_valid = 0;
        ibus_addr = '0; dbus_addr = '0; ibus_wdata = '0; dbus_wdata = '0;
        ibus_wstrb = '0; dbus_wstrb = '0;
        m_ready = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        mdl_last = 1; mdl_lock = 0; mdl_lock_id = 0; mdl_err = 0; mdl_q.delete();
        check("rst_pending", pending, 0);
        check("rst_err", err_rvalid, 0);
        check("rst_m_valid", m_valid, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Compare every DUT output with the model for the current inputs, then clock once.
    task automatic step();
        int  pend;
        bit  full, g, gv, mv, acc, head_ok;
        pend = mdl_q.size();
        full = (pend == MAXP);
        if (mdl_lock)                      g = mdl_lock_id;
        else if (ibus_valid && dbus_valid) g = ~mdl_last;
        else if (dbus_valid)               g = 1;
        else                               g = 0;
        gv  = g ? dbus_valid : ibus_valid;
        mv  = gv && !full;
        acc = mv && m_ready;
        head_ok = m_rvalid && (pend > 0);
        #1;
        check("pending", pending, pend);
        check("err", err_rvalid, mdl_err);
        check("m_valid", m_valid, mv);
        if (mv) begin
            check("m_addr",  m_addr,  g ? dbus_addr  : ibus_addr);
            check("m_wdata", m_wdata, g ? dbus_wdata : ibus_wdata);
            check("m_wstrb", m_wstrb, g ? dbus_wstrb : ibus_wstrb);
        end
        check("ibus_ready", ibus_ready, acc && !g);
        check("dbus_ready", dbus_ready, acc && g);
        check("ibus_rvalid", ibus_rvalid, head_ok && (mdl_q[0] == 0));
        check("dbus_rvalid", dbus_rvalid, head_ok && (mdl_q[0] == 1));
        if (head_ok) check("rdata", (mdl_q[0] ? dbus_rdata : ibus_rdata), m_rdata);
        @(posedge clk);
        if (head_ok) void'(mdl_q.pop_front());
        if (m_rvalid && pend == 0) mdl_err = 1;
        if (acc) begin
            if ((g ? dbus_wstrb : ibus_wstrb) == 4'h0) mdl_q.push_back(g);
            mdl_last = g;
            mdl_lock = 0;
        end else if (mv) begin
            mdl_lock    = 1;
            mdl_lock_id = g;
        end
        @(negedge clk);
    endtask

    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h0000_2000;

    initial begin
        rst = 1'b0;
        do_reset();

        // Conflict alternation: i, d, i, d, then full.
        ibus_valid = 1; ibus_addr = IA; dbus_valid = 1; dbus_addr = DA; m_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt_addr", m_addr, (k % 2 == 0) ? IA : DA);
            step();
            check("alt_pending", pending, k + 1);
        end
        #1;
        check("alt_full_mvalid", m_valid, 0);
        step();
        idle_inputs();
        m_rvalid = 1;
        for (int k = 0; k < 4; k++) begin
            m_rdata = $urandom;
            step();
        end
        m_rvalid = 0;
        check("alt_drained", pending, 0);

        // Lock: dbus held waiting, ibus arrives late, must not steal the grant.
        do_reset();
        dbus_valid = 1; dbus_addr = DA;
        for (int k = 0; k < 3; k++) begin
            if (k >= 1) begin ibus_valid = 1; ibus_addr = IA; end
            #1;
            check("lock_addr", m_addr, DA);
            check("lock_ibus_ready", ibus_ready, 0);
            step();
        end
        m_ready = 1;
        #1;
        check("lock_dbus_acc", dbus_ready, 1);
        step();
        #1;
        check("lock_ibus_next", ibus_ready, 1);
        step();
        idle_inputs();
        m_rvalid = 1;
        repeat (2) step();
        m_rvalid = 0;

        // Write: no tag pushed.
        do_reset();
        dbus_valid = 1; dbus_addr = DA; dbus_wstrb = 4'hF; dbus_wdata = 32'hCAFE_F00D; m_ready = 1;
        step();
        idle_inputs();
        check("wr_pending", pending, 0);
        repeat (2) step();

        // Routing i, d, i then responses A, B, C.
        do_reset();
        m_ready = 1;
        ibus_valid = 1; ibus_addr = IA; step();
        ibus_valid = 0; dbus_valid = 1; dbus_addr = DA; step();
        dbus_valid = 0; ibus_valid = 1; step();
        idle_inputs();
        m_rvalid = 1;
        m_rdata = 32'hAAAA_0001; #1; check("route_a", ibus_rvalid, 1); step();
        m_rdata = 32'hBBBB_0002; #1; check("route_b", dbus_rvalid, 1); step();
        m_rdata = 32'hCCCC_0003; #1; check("route_c", ibus_rvalid, 1); step();
        m_rvalid = 0;
        check("route_pending", pending, 0);

        // Full, then pop, then push with pop in the same cycle, then refill.
        do_reset();
        m_ready = 1; ibus_valid = 1; ibus_addr = IA;
        repeat (4) step();
        check("full_pending", pending, 4);
        ibus_valid = 0; m_rvalid = 1; step();
        check("full_pop", pending, 3);
        ibus_valid = 1; dbus_valid = 1; dbus_addr = DA; step();
        check("full_pushpop", pending, 3);
        m_rvalid = 0; step();
        check("full_refill", pending, 4);
        idle_inputs();
        m_rvalid = 1;
        repeat (4) step();
        m_rvalid = 0;

        // Spurious response sets the sticky flag; reset clears it.
        do_reset();
        m_rvalid = 1; step();
        m_rvalid = 0; step(); step();
        check("spur_err", err_rvalid, 1);
        do_reset();
        check("spur_cleared", err_rvalid, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            ibus_valid = ($urandom_range(99) < 60);
            dbus_valid = ($urandom_range(99) < 60);
            ibus_addr  = $urandom; dbus_addr = $urandom;
            ibus_wdata = $urandom; dbus_wdata = $urandom;
            ibus_wstrb = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
            dbus_wstrb = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
            m_ready    = ($urandom_range(99) < 70);
            m_rdata    = $urandom;
            if (mdl_q.size() > 0) m_rvalid = ($urandom_range(99) < 45);
            else                  m_rvalid = ($urandom_range(99) < 2);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
